// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages: write-back control bit
// positions, the memory-stage state encoding and the datapath word width.
package mips_pkg;

  localparam int WORD_W      = 32;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data RAM: synchronous write, registered synchronous read.
// Contents are deliberately not reset so the array maps onto block RAM.
module data_mem
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem_q[addr];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: resolves branches, sequences data-memory accesses through
// LATENCY wait states (raising stall meanwhile) and holds the MEM/WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [1:0]        wb_ctl,
  input  logic              branch,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              zero,
  input  logic [WORD_W-1:0] alu_result,
  input  logic [WORD_W-1:0] rdata2,
  input  logic [WORD_W-1:0] add_result,
  input  logic [4:0]        write_reg,
  output logic              pcsrc,
  output logic [WORD_W-1:0] branch_target,
  output logic              stall,
  output logic              misaligned,
  output logic [1:0]        wb_ctl_out,
  output logic [WORD_W-1:0] read_data,
  output logic [WORD_W-1:0] alu_result_out,
  output logic [4:0]        write_reg_out,
  output logic              valid_out
);

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              access;
  logic              aligned;
  logic              mem_access;
  logic              misaligned_acc;
  logic              complete;
  logic              ram_we;
  logic              ram_re;
  logic [WORD_W-1:0] ram_rdata;
  logic              load_q;
  logic [1:0]        wb_ctl_q;
  logic [WORD_W-1:0] alu_result_q;
  logic [4:0]        write_reg_q;
  logic              valid_q;
  logic              misaligned_q;

  assign pcsrc          = valid_in & branch & zero;
  assign branch_target  = add_result;

  assign access         = valid_in & (memread | memwrite);
  assign aligned        = (alu_result[1:0] == 2'b00);
  assign mem_access     = access & aligned;
  assign misaligned_acc = access & ~aligned;

  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_access) begin
          if (LATENCY == 0) begin
            complete = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
        end else begin
          complete = mem_access;
        end
      end
      default: begin
        stall    = 1'b0;
        complete = 1'b0;
      end
    endcase
  end

  // Load-and-store together commits the store; the read port stays idle so read_data is 0.
  assign ram_we = complete & memwrite;
  assign ram_re = complete & memread & ~memwrite;

  data_mem #(
    .ADDR_W(ADDR_W)
  ) u_data_mem (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (alu_result[ADDR_W+1:2]),
    .wdata(rdata2),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      wb_ctl_q     <= 2'b00;
      alu_result_q <= '0;
      write_reg_q  <= 5'd0;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      load_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_access && (LATENCY != 0)) begin
            state_q <= ST_WAIT;
            cnt_q   <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (stall || !valid_in) begin
        wb_ctl_q     <= 2'b00;
        alu_result_q <= '0;
        write_reg_q  <= 5'd0;
        valid_q      <= 1'b0;
        misaligned_q <= 1'b0;
        load_q       <= 1'b0;
      end else begin
        wb_ctl_q     <= wb_ctl;
        // A dropped access must never write the register file.
        if (misaligned_acc) begin
          wb_ctl_q[WB_REGWRITE] <= 1'b0;
        end
        alu_result_q <= alu_result;
        write_reg_q  <= write_reg;
        valid_q      <= 1'b1;
        misaligned_q <= misaligned_acc;
        load_q       <= ram_re;
      end
    end
  end

  // The RAM's output register holds the loaded word; load_q masks it to 0 otherwise.
  assign read_data      = load_q ? ram_rdata : '0;
  assign wb_ctl_out     = wb_ctl_q;
  assign alu_result_out = alu_result_q;
  assign write_reg_out  = write_reg_q;
  assign valid_out      = valid_q;
  assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances (LATENCY 0, 3, 4) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_mem_stage;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid_in [N];
  logic [1:0]  wb_ctl [N];
  logic        branch [N];
  logic        memread [N];
  logic        memwrite [N];
  logic        zero [N];
  logic [31:0] alu_result [N];
  logic [31:0] rdata2 [N];
  logic [31:0] add_result [N];
  logic [4:0]  write_reg [N];
  logic        pcsrc [N];
  logic [31:0] branch_target [N];
  logic        stall [N];
  logic        misaligned [N];
  logic [1:0]  wb_ctl_out [N];
  logic [31:0] read_data [N];
  logic [31:0] alu_result_out [N];
  logic [4:0]  write_reg_out [N];
  logic        valid_out [N];

  function automatic int lat_of(int d);
    case (d)
      0:       return 0;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      mem_stage #(
        .ADDR_W (8),
        .LATENCY(lat_of(gi))
      ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in[gi]),
        .wb_ctl        (wb_ctl[gi]),
        .branch        (branch[gi]),
        .memread       (memread[gi]),
        .memwrite      (memwrite[gi]),
        .zero          (zero[gi]),
        .alu_result    (alu_result[gi]),
        .rdata2        (rdata2[gi]),
        .add_result    (add_result[gi]),
        .write_reg     (write_reg[gi]),
        .pcsrc         (pcsrc[gi]),
        .branch_target (branch_target[gi]),
        .stall         (stall[gi]),
        .misaligned    (misaligned[gi]),
        .wb_ctl_out    (wb_ctl_out[gi]),
        .read_data     (read_data[gi]),
        .alu_result_out(alu_result_out[gi]),
        .write_reg_out (write_reg_out[gi]),
        .valid_out     (valid_out[gi])
      );
    end
  endgenerate

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Reference model: memory image, expected MEM/WB contents, and how many
  // cycles the current aligned access has already been held off.
  logic [31:0] mm [N][256];
  logic [1:0]  e_wb [N];
  logic [31:0] e_rd [N];
  logic [31:0] e_alu [N];
  logic [4:0]  e_wr [N];
  logic        e_val [N];
  logic        e_mis [N];
  int          stalled [N];

  function automatic logic exp_stall(int d);
    return valid_in[d] && (memread[d] || memwrite[d]) &&
           (alu_result[d][1:0] == 2'b00) && (stalled[d] < lat_of(d));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < N; d++) begin
      logic       acc;
      logic [7:0] idx;
      acc = valid_in[d] && (memread[d] || memwrite[d]);
      idx = alu_result[d][9:2];
      if (!rst_n || exp_stall(d) || !valid_in[d]) begin
        stalled[d] = (!rst_n) ? 0 : (exp_stall(d) ? stalled[d] + 1 : 0);
        e_wb[d]  = 2'b00;
        e_rd[d]  = 32'h0;
        e_alu[d] = 32'h0;
        e_wr[d]  = 5'd0;
        e_val[d] = 1'b0;
        e_mis[d] = 1'b0;
      end else begin
        stalled[d] = 0;
        e_wb[d]  = wb_ctl[d];
        e_alu[d] = alu_result[d];
        e_wr[d]  = write_reg[d];
        e_val[d] = 1'b1;
        e_mis[d] = 1'b0;
        e_rd[d]  = 32'h0;
        if (acc && alu_result[d][1:0] != 2'b00) begin
          e_wb[d][1] = 1'b0;
          e_mis[d]   = 1'b1;
        end else if (acc) begin
          if (memread[d] && !memwrite[d]) e_rd[d] = mm[d][idx];
          if (memwrite[d]) mm[d][idx] = rdata2[d];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      chk("pcsrc", d, pcsrc[d], valid_in[d] & branch[d] & zero[d]);
      chk("branch_target", d, branch_target[d], add_result[d]);
      chk("stall", d, stall[d], exp_stall(d));
      chk("misaligned", d, misaligned[d], e_mis[d]);
      chk("wb_ctl_out", d, wb_ctl_out[d], e_wb[d]);
      chk("read_data", d, read_data[d], e_rd[d]);
      chk("alu_result_out", d, alu_result_out[d], e_alu[d]);
      chk("write_reg_out", d, write_reg_out[d], e_wr[d]);
      chk("valid_out", d, valid_out[d], e_val[d]);
    end
  end

  task automatic idle(input int d);
    valid_in[d]   = 1'b0;
    wb_ctl[d]     = 2'b00;
    branch[d]     = 1'b0;
    memread[d]    = 1'b0;
    memwrite[d]   = 1'b0;
    zero[d]       = 1'b0;
    alu_result[d] = 32'h0;
    rdata2[d]     = 32'h0;
    add_result[d] = 32'h0;
    write_reg[d]  = 5'd0;
  endtask

  // Presents one access, holds it through any stall, returns the stall count.
  // Returns 3 time units after the completing edge with the inputs idled.
  task automatic access(input int d, input logic rd, input logic wr, input logic [1:0] wb,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wreg, output int nstall);
    valid_in[d]   = 1'b1;
    memread[d]    = rd;
    memwrite[d]   = wr;
    wb_ctl[d]     = wb;
    alu_result[d] = addr;
    rdata2[d]     = data;
    write_reg[d]  = wreg;
    nstall = 0;
    #1;
    while (stall[d] === 1'b1 && nstall < 40) begin
      if (nstall > 0) chk("valid_out_in_stall", d, valid_out[d], 1'b0);
      nstall++;
      @(posedge clk);
      #3;
    end
    if (nstall >= 40) chk("stall_timeout", d, nstall, 0);
    @(posedge clk);
    #2;
    idle(d);
    #1;
  endtask

  initial begin
    int ns;
    for (int d = 0; d < N; d++) idle(d);
    #1;
    chk("reset_valid_out", 0, valid_out[0], 1'b0);
    chk("reset_misaligned", 2, misaligned[2], 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #3;

    // LATENCY=0 store then load.
    access(0, 1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 5'd0, ns);
    chk("t1_store_stalls", 0, ns, 0);
    access(0, 1'b1, 1'b0, 2'b11, 32'h10, 32'h0, 5'd8, ns);
    chk("t1_load_stalls", 0, ns, 0);
    chk("t1_read_data", 0, read_data[0], 32'hDEADBEEF);
    chk("t1_write_reg_out", 0, write_reg_out[0], 5'd8);
    chk("t1_valid_out", 0, valid_out[0], 1'b1);

    // Branch resolution is combinational.
    valid_in[0] = 1'b1; branch[0] = 1'b1; zero[0] = 1'b1; add_result[0] = 32'h40;
    #1;
    chk("t3_pcsrc_taken", 0, pcsrc[0], 1'b1);
    chk("t3_branch_target", 0, branch_target[0], 32'h40);
    zero[0] = 1'b0;
    #1;
    chk("t3_pcsrc_not_taken", 0, pcsrc[0], 1'b0);
    @(posedge clk);
    #2;
    idle(0);
    #1;

    // Misaligned store is dropped.
    access(0, 1'b0, 1'b1, 2'b10, 32'h13, 32'h1234, 5'd3, ns);
    chk("t4_no_stall", 0, ns, 0);
    chk("t4_misaligned", 0, misaligned[0], 1'b1);
    chk("t4_regwrite_cleared", 0, wb_ctl_out[0][1], 1'b0);
    chk("t4_valid_out", 0, valid_out[0], 1'b1);
    access(0, 1'b1, 1'b0, 2'b11, 32'h10, 32'h0, 5'd4, ns);
    chk("t4_read_back", 0, read_data[0], 32'hDEADBEEF);
    chk("t4_misaligned_cleared", 0, misaligned[0], 1'b0);

    // Address wrap modulo the depth.
    access(0, 1'b0, 1'b1, 2'b00, 32'h400, 32'hA5A5A5A5, 5'd0, ns);
    access(0, 1'b1, 1'b0, 2'b11, 32'h000, 32'h0, 5'd5, ns);
    chk("t5_wrap_read", 0, read_data[0], 32'hA5A5A5A5);

    // Load and store together: store commits, read_data is 0.
    access(0, 1'b1, 1'b1, 2'b11, 32'h30, 32'hCAFE, 5'd6, ns);
    chk("both_read_data", 0, read_data[0], 32'h0);
    access(0, 1'b1, 1'b0, 2'b11, 32'h30, 32'h0, 5'd6, ns);
    chk("both_store_done", 0, read_data[0], 32'hCAFE);

    // LATENCY=3.
    access(1, 1'b0, 1'b1, 2'b00, 32'h8, 32'h77, 5'd0, ns);
    chk("t2_store_stalls", 1, ns, 3);
    access(1, 1'b1, 1'b0, 2'b11, 32'h8, 32'h0, 5'd9, ns);
    chk("t2_load_stalls", 1, ns, 3);
    chk("t2_read_data", 1, read_data[1], 32'h77);
    chk("t2_valid_out", 1, valid_out[1], 1'b1);

    // LATENCY=4, reset during the second stall cycle.
    access(2, 1'b0, 1'b1, 2'b00, 32'h20, 32'h11, 5'd0, ns);
    chk("t6_first_store_stalls", 2, ns, 4);
    valid_in[2] = 1'b1; memwrite[2] = 1'b1; alu_result[2] = 32'h20; rdata2[2] = 32'h55;
    #1;
    chk("t6_stall_first", 2, stall[2], 1'b1);
    @(posedge clk);
    #2;
    chk("t6_stall_second", 2, stall[2], 1'b1);
    rst_n = 1'b0;
    idle(2);
    #1;
    chk("t6_rst_valid_out", 2, valid_out[2], 1'b0);
    chk("t6_rst_wb_ctl_out", 2, wb_ctl_out[2], 2'b00);
    chk("t6_rst_read_data", 2, read_data[2], 32'h0);
    chk("t6_rst_alu_result_out", 2, alu_result_out[2], 32'h0);
    chk("t6_rst_write_reg_out", 2, write_reg_out[2], 5'd0);
    chk("t6_rst_misaligned", 2, misaligned[2], 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    access(2, 1'b1, 1'b0, 2'b11, 32'h20, 32'h0, 5'd7, ns);
    chk("t6_load_stalls", 2, ns, 4);
    chk("t6_store_aborted", 2, read_data[2], 32'h11);

    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
